// File: rtl/paicore_tx_dispatch_if.sv
// Beat-in / link-out bundle for the PAICORE transmit dispatcher.
// The master drives beats and ACKs; the slave (dispatcher) drives REQ/pdata.
interface paicore_tx_dispatch_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int PDATA_WIDTH = 32,
  parameter int CH_NUM      = 4
);
  logic                          s_axis_tvalid;
  logic                          s_axis_tready;
  logic [DATA_WIDTH-1:0]         s_axis_tdata;
  logic                          s_axis_tlast;
  logic [CH_NUM-1:0]             req;
  logic [CH_NUM-1:0]             ack;
  logic [CH_NUM*PDATA_WIDTH-1:0] pdata;

  modport master (
    output s_axis_tvalid, s_axis_tdata,
    output s_axis_tlast, ack,
    input  s_axis_tready, req, pdata
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata,
    input  s_axis_tlast, ack,
    output s_axis_tready, req, pdata
  );
endinterface

// File: rtl/paicore_tx_dispatch.sv
// AXIS beat to multi-channel four-phase REQ/ACK link dispatcher.
// `define TX_TIMEOUT_EN adds per-channel ACK timeout and timeout_err.
module paicore_tx_dispatch #(
  parameter int DATA_WIDTH     = 64,
  parameter int PDATA_WIDTH    = 32,
  parameter int CH_NUM         = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_aresetn,
  input  logic                 start,
  input  logic [CH_NUM-1:0]    ch_en,
  input  logic                 single_channel,
  input  logic [CNT_WIDTH-1:0] send_len,
  paicore_tx_dispatch_if.slave bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sent_cnt,
  output logic                 tx_done
`ifdef TX_TIMEOUT_EN
  ,
  output logic [CH_NUM-1:0]    timeout_err
`endif
);
  localparam int WORDS = DATA_WIDTH / PDATA_WIDTH;
  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    T_IDLE, T_RUN, T_DRAIN, T_DONE
  } top_t;

  typedef enum logic [1:0] {
    C_IDLE, C_REQ, C_REL
  } ch_t;

  top_t                   r_tst, w_tnxt;
  ch_t                    r_cst  [CH_NUM];
  ch_t                    w_cnxt [CH_NUM];
  logic [IDX_W-1:0]       r_widx [CH_NUM];
  logic [DATA_WIDTH-1:0]  r_hold [CH_NUM];
  logic [DATA_WIDTH-1:0]  w_nhold[CH_NUM];
  logic [PDATA_WIDTH-1:0] r_pd   [CH_NUM];

  logic [CH_NUM-1:0]    r_ack_m, r_ack_s;
  logic [CH_NUM-1:0]    r_mask, w_eff;
  logic [CH_NUM-1:0]    w_load, w_req, w_idle;
  logic [CNT_WIDTH-1:0] r_len, r_cnt;
  logic [PTR_W-1:0]     r_ptr, w_nptr, w_first;
  logic                 w_accept, w_tready;
  logic                 w_start, w_found;
  logic                 r_tx_done;
  int                   w_idx;

  // Single-channel mode keeps only the lowest set bit of the mask.
  assign w_eff = single_channel
               ? (ch_en & (~ch_en + CH_NUM'(1)))
               : ch_en;

  assign w_start  = start && (r_tst == T_IDLE);
  assign w_tready = (r_tst == T_RUN)
                 && w_idle[r_ptr]
                 && (r_cnt < r_len);
  assign w_accept = bus.s_axis_tvalid && w_tready;

  assign bus.s_axis_tready = w_tready;
  assign bus.req           = w_req;
  assign busy     = (r_tst == T_RUN)
                 || (r_tst == T_DRAIN);
  assign sent_cnt = r_cnt;
  assign tx_done  = r_tx_done;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign w_req[g]   = (r_cst[g] == C_REQ);
    assign w_idle[g]  = (r_cst[g] == C_IDLE);
    assign w_load[g]  = w_accept
                     && (r_ptr == PTR_W'(g));
    assign w_nhold[g] = r_hold[g] << PDATA_WIDTH;
    assign bus.pdata[g*PDATA_WIDTH +: PDATA_WIDTH]
                      = r_pd[g];
  end

  always_comb begin
    w_first = '0;
    for (int c = CH_NUM - 1; c >= 0; c--)
      if (w_eff[c]) w_first = PTR_W'(c);
  end

  always_comb begin
    w_nptr  = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= CH_NUM; k++) begin
      w_idx = (int'(r_ptr) + k) % CH_NUM;
      if (!w_found && r_mask[PTR_W'(w_idx)]) begin
        w_nptr  = PTR_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     r_tcnt [CH_NUM];
  logic [CH_NUM-1:0] w_to, r_err;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_to
    assign w_to[g] = (r_cst[g] != C_IDLE)
                  && (r_tcnt[g] == TW'(TIMEOUT_CYCLES - 1));
  end
  assign timeout_err = r_err;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_err <= '0;
      for (int c = 0; c < CH_NUM; c++)
        r_tcnt[c] <= '0;
    end else begin
      r_err <= w_start ? '0 : (r_err | w_to);
      for (int c = 0; c < CH_NUM; c++)
        if (r_cst[c] == C_IDLE || w_cnxt[c] != r_cst[c])
          r_tcnt[c] <= '0;
        else
          r_tcnt[c] <= r_tcnt[c] + 1'b1;
    end
  end
`endif

  always_comb begin
    w_tnxt = r_tst;
    unique case (r_tst)
      T_IDLE:
        if (w_start)
          w_tnxt = (send_len == '0 || w_eff == '0)
                 ? T_DONE : T_RUN;
      T_RUN:
        if (w_accept && (bus.s_axis_tlast
            || (r_cnt + 1'b1) == r_len))
          w_tnxt = T_DRAIN;
      T_DRAIN:
        if (&w_idle) w_tnxt = T_DONE;
      T_DONE:  w_tnxt = T_IDLE;
      default: w_tnxt = T_IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      w_cnxt[c] = r_cst[c];
      unique case (r_cst[c])
        C_IDLE: if (w_load[c]) w_cnxt[c] = C_REQ;
        C_REQ:  if (r_ack_s[c]) w_cnxt[c] = C_REL;
        C_REL:
          if (!r_ack_s[c])
            w_cnxt[c] = (r_widx[c] == IDX_W'(WORDS - 1))
                      ? C_IDLE : C_REQ;
        default: w_cnxt[c] = C_IDLE;
      endcase
`ifdef TX_TIMEOUT_EN
      if (w_to[c]) w_cnxt[c] = C_IDLE;
`endif
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_tst     <= T_IDLE;
      r_ack_m   <= '0;
      r_ack_s   <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_tx_done <= 1'b0;
    end else begin
      r_tst     <= w_tnxt;
      r_ack_m   <= bus.ack;
      r_ack_s   <= r_ack_m;
      r_tx_done <= (r_tst == T_DONE);
      if (w_start) begin
        r_mask <= w_eff;
        r_len  <= send_len;
        r_cnt  <= '0;
        r_ptr  <= w_first;
      end else if (w_accept) begin
        r_cnt  <= r_cnt + 1'b1;
        r_ptr  <= w_nptr;
      end
    end
  end

  // Words go out most-significant first by shifting the holding register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int c = 0; c < CH_NUM; c++) begin
        r_cst[c]  <= C_IDLE;
        r_widx[c] <= '0;
        r_hold[c] <= '0;
        r_pd[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        r_cst[c] <= w_cnxt[c];
        if (w_load[c]) begin
          r_hold[c] <= bus.s_axis_tdata;
          r_pd[c]   <= bus.s_axis_tdata[DATA_WIDTH-1 -: PDATA_WIDTH];
          r_widx[c] <= '0;
        end else if (r_cst[c] == C_REL && w_cnxt[c] == C_REQ) begin
          r_hold[c] <= w_nhold[c];
          r_pd[c]   <= w_nhold[c][DATA_WIDTH-1 -: PDATA_WIDTH];
          r_widx[c] <= r_widx[c] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_paicore_tx_dispatch.sv
// Directed bench for paicore_tx_dispatch with per-channel word scoreboard.
// A negedge ACK responder pops and compares expected link words.
module tb_paicore_tx_dispatch;
  localparam int DW = 64;
  localparam int PW = 32;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          single = 1'b0;
  logic [CH-1:0] ch_en = '0;
  logic [CW-1:0] send_len = '0;
  logic          busy, tx_done;
  logic [CW-1:0] sent_cnt;
`ifdef TX_TIMEOUT_EN
  logic [CH-1:0] timeout_err;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int ack_dly = 0;
  logic [CH-1:0] stuck = '0;
  logic [PW-1:0] exp_q [CH][$];
  logic [PW-1:0] cap [CH];
  int            dcnt [CH];

  paicore_tx_dispatch_if #(
    .DATA_WIDTH(DW), .PDATA_WIDTH(PW), .CH_NUM(CH)
  ) bus ();

  paicore_tx_dispatch #(
    .DATA_WIDTH(DW), .PDATA_WIDTH(PW), .CH_NUM(CH),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_aresetn(rst_n),
    .start(start),
    .ch_en(ch_en),
    .single_channel(single),
    .send_len(send_len),
    .bus(bus.slave),
    .busy(busy),
    .sent_cnt(sent_cnt),
    .tx_done(tx_done)
`ifdef TX_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Link-side device: answers each REQ edge after ack_dly negedges.
  always @(negedge clk) begin : resp
    logic [PW-1:0] w;
    for (int c = 0; c < CH; c++) begin
      w = bus.pdata[c*PW +: PW];
      if (!rst_n) begin
        bus.ack[c] = 1'b0;
        dcnt[c] = 0;
      end else if (!stuck[c] && bus.req[c] != bus.ack[c]) begin
        if (dcnt[c] >= ack_dly) begin
          dcnt[c] = 0;
          if (bus.req[c]) begin
            if (exp_q[c].size() == 0)
              chk($sformatf("unexp_req%0d", c),
                  64'(bus.req[c]), 64'd0);
            else
              chk($sformatf("word_ch%0d", c),
                  64'(w), 64'(exp_q[c].pop_front()));
            cap[c] = w;
            bus.ack[c] = 1'b1;
          end else begin
            chk($sformatf("pdata_stable%0d", c),
                64'(w), 64'(cap[c]));
            bus.ack[c] = 1'b0;
          end
        end else begin
          dcnt[c]++;
        end
      end else begin
        dcnt[c] = 0;
      end
    end
  end

  task automatic pulse_start(input logic [CH-1:0] en,
                             input logic sc,
                             input logic [CW-1:0] len);
    @(negedge clk);
    ch_en = en; single = sc; send_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d,
                           input logic last, input int ch);
    int i = 0;
    logic ok;
    exp_q[ch].push_back(d[DW-1 -: PW]);
    exp_q[ch].push_back(d[PW-1:0]);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = d;
    bus.s_axis_tlast = last;
    while (!bus.s_axis_tready && i < 400) begin
      @(negedge clk);
      i++;
    end
    ok = bus.s_axis_tready;
    chk("beat_accept", 64'(ok), 64'd1);
    if (ok)
      chk("tgt_idle_at_accept",
          64'({bus.req[ch], bus.ack[ch]}), 64'd0);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input logic [CW-1:0] exp_cnt);
    int i = 0;
    int left = 0;
    while (!tx_done && i < 3000) begin
      @(negedge clk);
      i++;
    end
    for (int c = 0; c < CH; c++) left += exp_q[c].size();
    chk("tx_done", 64'(tx_done), 64'd1);
    chk("sent_cnt", 64'(sent_cnt), 64'(exp_cnt));
    chk("req_idle_at_done", 64'(bus.req), 64'd0);
    chk("ack_low_at_done", 64'(bus.ack), 64'd0);
    chk("words_left", 64'(left), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(tx_done), 64'd0);
  endtask

  task automatic degen(input logic [CH-1:0] en,
                       input logic [CW-1:0] len);
    @(negedge clk);
    ch_en = en; single = 1'b0; send_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("degen_not_yet", 64'(tx_done), 64'd0);
    chk("degen_tready", 64'(bus.s_axis_tready), 64'd0);
    @(negedge clk);
    chk("degen_done", 64'(tx_done), 64'd1);
    chk("degen_req", 64'(bus.req), 64'd0);
    chk("degen_tready2", 64'(bus.s_axis_tready), 64'd0);
    @(negedge clk);
    chk("degen_pulse", 64'(tx_done), 64'd0);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(bus.req), 64'd0);
    chk("rst_pdata", 64'(bus.pdata), 64'd0);
    chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sent_cnt", 64'(sent_cnt), 64'd0);
    chk("rst_tx_done", 64'(tx_done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin over all four channels
    pulse_start(4'b1111, 1'b0, 4);
    chk("rr_busy", 64'(busy), 64'd1);
    send_beat(64'hA0A0_0001_A1A1_0002, 1'b0, 0);
    send_beat(64'hB0B0_0003_B1B1_0004, 1'b0, 1);
    send_beat(64'hC0C0_0005_C1C1_0006, 1'b0, 2);
    send_beat(64'hD0D0_0007_D1D1_0008, 1'b0, 3);
    chk("rr_tready_at_len", 64'(bus.s_axis_tready), 64'd0);
    wait_done(4);

    // Single-channel mode: lowest set bit of 0110 is channel 1
    pulse_start(4'b0110, 1'b1, 3);
    send_beat(64'h1111_2222_3333_4444, 1'b0, 1);
    send_beat(64'h5555_6666_7777_8888, 1'b0, 1);
    send_beat(64'h9999_AAAA_BBBB_CCCC, 1'b0, 1);
    wait_done(3);

    // Early tlast on beat 3 of 10
    pulse_start(4'b1111, 1'b0, 10);
    send_beat(64'h0101_0101_0202_0202, 1'b0, 0);
    send_beat(64'h0303_0303_0404_0404, 1'b0, 1);
    send_beat(64'h0505_0505_0606_0606, 1'b1, 2);
    chk("tlast_tready", 64'(bus.s_axis_tready), 64'd0);
    chk("tlast_busy", 64'(busy), 64'd1);
    chk("tlast_cnt", 64'(sent_cnt), 64'd3);
    wait_done(3);

    // Degenerate starts
    degen(4'b1111, 0);
    degen(4'b0000, 5);

    // Slow ACK, 7 negedges per edge
    ack_dly = 7;
    pulse_start(4'b1111, 1'b0, 4);
    send_beat(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0);
    send_beat(64'h0123_4567_89AB_CDEF, 1'b0, 1);
    send_beat(64'hFEDC_BA98_7654_3210, 1'b0, 2);
    send_beat(64'h1357_9BDF_2468_ACE0, 1'b0, 3);
    wait_done(4);

    // Reset while channel 0 sits in REQ
    pulse_start(4'b1111, 1'b0, 4);
    send_beat(64'hAAAA_5555_5555_AAAA, 1'b0, 0);
    chk("pre_rst_req", 64'(bus.req[0]), 64'd1);
    chk("pre_rst_cnt", 64'(sent_cnt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(bus.req), 64'd0);
    chk("rst_mid_cnt", 64'(sent_cnt), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    for (int c = 0; c < CH; c++) exp_q[c].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start(4'b0011, 1'b0, 2);
    send_beat(64'h7777_0000_0000_7777, 1'b0, 0);
    send_beat(64'h8888_1111_1111_8888, 1'b0, 1);
    wait_done(2);
    ack_dly = 0;

`ifdef TX_TIMEOUT_EN
    // Channel 2 never answers
    stuck = 4'b0100;
    pulse_start(4'b0100, 1'b0, 1);
    send_beat(64'h2222_3333_4444_5555, 1'b0, 2);
    exp_q[2].delete();
    wait_done(1);
    chk("timeout_err", 64'(timeout_err), 64'h4);
    stuck = '0;
    degen(4'b0001, 0);
    chk("timeout_clr", 64'(timeout_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/paicore_tx_dispatch.md
Name: paicore_tx_dispatch

Overview:
- Multi-channel transmit dispatcher between the S2MM-side AXI-Stream input and the PAICORE parallel input links.
- Accepts DATA_WIDTH-bit frame beats and splits each beat into WORDS = DATA_WIDTH/PDATA_WIDTH link words.
- Sends the words on one of CH_NUM four-phase REQ/ACK channels, selected round-robin over an enable mask or fixed in single-channel mode.
- Counts beats against a programmed length and pulses tx_done once every channel has drained.

Parameters:
- DATA_WIDTH, 64, AXIS beat width; must be an integer multiple of PDATA_WIDTH.
- PDATA_WIDTH, 32, link word width per channel.
- CH_NUM, 4, number of link channels (1..16).
- CNT_WIDTH, 32, width of send_len and sent_cnt.
- TIMEOUT_CYCLES, 1024, ACK timeout limit; used only with TX_TIMEOUT_EN.

Ports:
- s_axis_aclk  in  1  sole clock.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches configuration and starts a transfer.
- ch_en  in  CH_NUM  channel enable mask, sampled on start.
- single_channel  in  1  when 1, only the lowest set bit of ch_en is used; sampled on start.
- send_len  in  CNT_WIDTH  number of beats to send; sampled on start.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tdata  in  DATA_WIDTH  input beat.
- s_axis_tlast  in  1  early end of transfer.
- req  out  CH_NUM  per-channel request.
- pdata  out  CH_NUM*PDATA_WIDTH  per-channel word; channel c occupies bits [c*PDATA_WIDTH +: PDATA_WIDTH].
- ack  in  CH_NUM  per-channel acknowledge; asynchronous to the clock.
- busy  out  1  transfer in progress.
- sent_cnt  out  CNT_WIDTH  number of beats accepted since the last start.
- tx_done  out  1  single-cycle completion pulse.

Behaviour:
- Clocking and reset:
  - One clock, s_axis_aclk. Reset is asynchronous and active-low on s_axis_aresetn.
  - Reset values: req=0, pdata=0, s_axis_tready=0, busy=0, sent_cnt=0, tx_done=0. All FSMs go to IDLE and the round-robin pointer goes to 0.
  - Reset mid-handshake drops req immediately; no recovery of the lost word is attempted.
- ACK synchronisation:
  - Each ack bit passes through a 2-flop synchroniser; the output is ack_s.
  - All handshake decisions use ack_s only.
- Top FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch the configuration and clear sent_cnt.
    - If send_len==0 or the effective mask is 0, go to DONE.
    - Otherwise go to RUN.
  - RUN: go to DRAIN when sent_cnt reaches send_len, or when a beat with tlast is accepted.
  - DRAIN: wait until every channel FSM is IDLE, then go to DONE.
  - DONE: tx_done=1 for exactly one cycle, then return to IDLE.
  - busy=1 in RUN and DRAIN.
  - start is ignored outside IDLE.
- Channel selection:
  - Target channel = rr_ptr, which always points to an enabled channel.
  - In single-channel mode the target is fixed to the lowest set bit of ch_en.
  - After each accepted beat, rr_ptr advances to the next enabled channel with wrap-around.
- Input handshake:
  - s_axis_tready = RUN && target channel FSM is IDLE && sent_cnt < send_len.
  - A beat is accepted when tvalid && tready. On acceptance: load the beat into the target channel's holding register and increment sent_cnt.
  - There is no combinational path from ack to tready.
- Channel FSM states (one FSM per channel): IDLE, REQ, REL.
  - A word index widx runs from 0 to WORDS-1.
  - Word order is most-significant first: word 0 = tdata[DATA_WIDTH-1 -: PDATA_WIDTH].
  - IDLE: on load, set widx=0 and go to REQ. pdata shows word 0 and req rises in the cycle after acceptance.
  - REQ: req=1, pdata held stable. When ack_s=1, go to REL.
  - REL: req=0, pdata held stable. When ack_s=0:
    - if widx==WORDS-1, go to IDLE;
    - otherwise increment widx, present the next word and go to REQ.
  - pdata keeps the last word after the channel returns to IDLE.
- Boundary conditions:
  - tlast on the final counted beat has the same effect as reaching the count.
  - sent_cnt saturates at send_len, so no wrap-around is possible.
  - Disabled channels keep req=0 permanently.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- With the macro defined:
  - Each channel has a cycle counter that runs in REQ and REL and clears on every state change.
  - When a counter reaches TIMEOUT_CYCLES, that channel forces req=0 and returns to IDLE, abandoning the beat.
  - An extra output port timeout_err (out, CH_NUM) carries sticky per-channel flags, cleared by start.
- Without the macro: neither the counters nor the port exist, and a channel waits indefinitely for ack.

Test Plan:
- Round-robin, two words: ch_en=4'b1111, single_channel=0, send_len=4, beats A..D, immediate ack responder.
  - Required: A, B, C, D sent on channels 0, 1, 2, 3 respectively, each as high word then low word.
  - Required: sent_cnt=4, then exactly one tx_done pulse, after the last req falls and ack_s=0.
- Single-channel mode: ch_en=4'b0110, single_channel=1, send_len=3.
  - Required: all beats go to channel 1; channels 0, 2 and 3 keep req=0.
  - Required: tready stays 0 while channel 1 is not IDLE.
- Early tlast: send_len=10, tlast on beat 3.
  - Required: tready=0 from the next cycle; sent_cnt=3; tx_done after drain.
- Degenerate start: send_len=0 (and separately ch_en=0).
  - Required: tx_done two cycles after start, tready never asserted, req stays 0.
- Slow ack: ack delayed by 7 cycles per edge.
  - Required: pdata stable through every REQ/REL pair.
  - Required: a reset mid-REQ drops req in the same cycle and clears sent_cnt to 0.
- TX_TIMEOUT_EN with TIMEOUT_CYCLES=16: ack stuck at 0 on channel 2.
  - Required: timeout_err[2]=1 after 16 cycles in REQ, channel 2 returns IDLE, transfer completes with tx_done.
